// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO burst reader.
//   rd_state_e        : controller states (IDLE, READ, DRAIN)
//   DEFAULT_BURST_LEN : burst length used when the top is not overridden
//   BUF_DEPTH         : number of entries in the output buffer
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    localparam int DEFAULT_BURST_LEN = 4;
    localparam int BUF_DEPTH         = 2;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer between the FIFO read port and the output stream.
// Each entry carries {last, data}.
//   clk, rst   : clock and synchronous active-high reset
//   push       : write push_data into the tail entry
//   push_data  : {last, data} of the captured word
//   pop        : remove the head entry (consumer accepted it)
//   head_data  : {last, data} of the head entry
//   head_valid : buffer holds at least one entry
//   occ        : current number of stored entries (0..2)
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [WIDTH-1:0] mem_d [BUF_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic             pop_ok, push_ok;

    // Pop is only honoured with data present; push is honoured when there is
    // room, counting the slot freed by a same-cycle pop.
    always_comb begin
        pop_ok   = pop && (occ_q != 2'd0);
        push_ok  = push && ((occ_q != 2'(BUF_DEPTH)) || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push_ok && !pop_ok) begin
            occ_d = occ_q + 2'd1;
        end else if (!push_ok && pop_ok) begin
            occ_d = occ_q - 2'd1;
        end
    end

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head_data  = mem_q[rd_ptr_q];
    assign head_valid = (occ_q != 2'd0);
    assign occ        = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the synchronous FIFO. Watches the FIFO flags,
// issues read strobes in bursts of up to BURST_LEN words and forwards the
// returned words on a valid/ready stream, marking the final word of each burst.
//   clk, rst        : clock and synchronous active-high reset
//   enable          : allows new bursts to start
//   flush           : allows a burst to start below the FIFO threshold
//   fifo_rd         : read strobe to the FIFO
//   fifo_data       : FIFO read data, valid the cycle after fifo_rd
//   fifo_empty      : FIFO empty flag
//   fifo_threshold  : FIFO at or above its threshold
//   fifo_underflow  : FIFO underflow flag
//   m_data/m_valid/m_ready/m_last : output stream
//   busy            : controller is not idle
//   err_underflow   : sticky underflow indication
//   word_count      : words accepted on the output, modulo 2^16
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              flush,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    input  logic              fifo_threshold,
    input  logic              fifo_underflow,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              err_underflow,
    output logic [15:0]       word_count
);

    localparam logic [7:0] BURST_CNT = 8'(BURST_LEN);

    rd_state_e   state_q, state_d;
    logic [7:0]  rd_cnt_q, rd_cnt_d;
    logic        inflight_q, inflight_d;
    logic        err_underflow_q, err_underflow_d;
    logic [15:0] word_count_q, word_count_d;

    logic              pop;
    logic              cap_last;
    logic              room;
    logic              rd_issue;
    logic [2:0]        ahead;
    logic [DATA_W:0]   head_data;
    logic              head_valid;
    logic [1:0]        occ;

    fifo_rd_skid #(
        .WIDTH (DATA_W + 1)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_data  ({cap_last, fifo_data}),
        .pop        (pop),
        .head_data  (head_data),
        .head_valid (head_valid),
        .occ        (occ)
    );

    // Next-state logic. A word returned this cycle is the last of its burst
    // when it completes BURST_LEN reads (rd_cnt already counts it) or when the
    // FIFO ran dry behind it. The occupancy term counts the word still in
    // flight so the two-entry buffer can never overflow.
    always_comb begin
        state_d         = state_q;
        rd_cnt_d        = rd_cnt_q;
        pop             = head_valid && m_ready;
        cap_last        = (rd_cnt_q == BURST_CNT) || fifo_empty;
        ahead           = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
        room            = (ahead < 3'd2);
        rd_issue        = (state_q == ST_READ) && !fifo_empty &&
                          (rd_cnt_q < BURST_CNT) &&
                          !(inflight_q && cap_last) && room;
        inflight_d      = rd_issue;
        err_underflow_d = err_underflow_q | fifo_underflow;
        word_count_d    = word_count_q + {15'd0, pop};

        if (rd_issue) begin
            rd_cnt_d = rd_cnt_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable && !fifo_empty && (fifo_threshold || flush)) begin
                    state_d  = ST_READ;
                    rd_cnt_d = 8'd0;
                end
            end
            ST_READ: begin
                if (inflight_q && cap_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((occ == 2'd0) || ((occ == 2'd1) && pop)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset also discards any word still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            rd_cnt_q        <= 8'd0;
            inflight_q      <= 1'b0;
            err_underflow_q <= 1'b0;
            word_count_q    <= 16'd0;
        end else begin
            state_q         <= state_d;
            rd_cnt_q        <= rd_cnt_d;
            inflight_q      <= inflight_d;
            err_underflow_q <= err_underflow_d;
            word_count_q    <= word_count_d;
        end
    end

    assign fifo_rd       = rd_issue;
    assign m_data        = head_data[DATA_W-1:0];
    assign m_last        = head_data[DATA_W] && head_valid;
    assign m_valid       = head_valid;
    assign busy          = (state_q != ST_IDLE);
    assign err_underflow = err_underflow_q;
    assign word_count    = word_count_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader. A simple synchronous FIFO model
// feeds the DUT; a queue-level reference model predicts the delivered words
// and their framing, and a negedge monitor scores every accepted word.
module tb_fifo_burst_reader;

    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 4;
    localparam int THR       = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    logic              clk            = 1'b0;
    logic              rst            = 1'b1;
    logic              enable         = 1'b0;
    logic              flush          = 1'b0;
    logic              fifo_rd;
    logic [DATA_W-1:0] fifo_data      = '0;
    logic              fifo_empty     = 1'b1;
    logic              fifo_threshold = 1'b0;
    logic              fifo_underflow = 1'b0;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready        = 1'b1;
    logic              m_last;
    logic              busy;
    logic              err_underflow;
    logic [15:0]       word_count;

    int                checks  = 0;
    int                errors  = 0;
    logic [DATA_W-1:0] phys_q[$];
    logic [DATA_W-1:0] model_q[$];
    exp_t              exp_q[$];
    logic [15:0]       exp_wc  = 16'd0;
    int                rd_total = 0;
    int                cyc      = 0;
    int                outstanding = 0;
    int                ready_mode = 0;
    logic              ready_fixed = 1'b1;
    int                ready_pct = 100;
    int                pat_idx = 0;
    bit                gapless = 1'b0;

    bit                prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    bit                have_prev = 1'b0;
    bit                prev_last = 1'b0;
    int                prev_cyc = 0;
    exp_t              mon_e;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .flush          (flush),
        .fifo_rd        (fifo_rd),
        .fifo_data      (fifo_data),
        .fifo_empty     (fifo_empty),
        .fifo_threshold (fifo_threshold),
        .fifo_underflow (fifo_underflow),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last),
        .busy           (busy),
        .err_underflow  (err_underflow),
        .word_count     (word_count)
    );

    // Synchronous FIFO model: read data and post-read flags appear after the edge.
    always @(posedge clk) begin
        logic [DATA_W-1:0] w;
        if (fifo_rd && phys_q.size() > 0) begin
            w = phys_q.pop_front();
            fifo_data <= w;
        end
        fifo_empty     <= (phys_q.size() == 0);
        fifo_threshold <= (phys_q.size() >= THR);
    end

    // Consumer ready generator: fixed, random percentage, or 1,0,0 pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: m_ready = ready_fixed;
                1: m_ready = ($urandom_range(0, 99) < ready_pct);
                default: begin
                    m_ready = (pat_idx == 0);
                    pat_idx = (pat_idx + 1) % 3;
                end
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
                     name, actual, expected, cyc);
        end
    endtask

    // Monitor: scores accepted words, stall stability, gapless bursts and read-ahead.
    always @(negedge clk) begin
        cyc++;
        if (fifo_rd) rd_total++;
        if (rst) begin
            outstanding = 0;
            prev_stall  = 1'b0;
            have_prev   = 1'b0;
        end else begin
            if (prev_stall) begin
                checkOutput("stall_valid", 32'(m_valid), 32'd1);
                checkOutput("stall_data", m_data, prev_data);
            end
            if (fifo_rd) outstanding++;
            if (m_valid && m_ready) begin
                outstanding--;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word at cycle %0d",
                             m_data, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("m_data", m_data, mon_e.data);
                    checkOutput("m_last", 32'(m_last), 32'(mon_e.last));
                end
                if (gapless && have_prev && !prev_last)
                    checkOutput("gapless", 32'(cyc - prev_cyc), 32'd1);
                have_prev = 1'b1;
                prev_last = m_last;
                prev_cyc  = cyc;
            end
            if (fifo_rd) checkOutput("read_ahead_le2", 32'(outstanding <= 2), 32'd1);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeWord(input logic [DATA_W-1:0] d);
        phys_q.push_back(d);
        model_q.push_back(d);
    endtask

    // Reference: the next n FIFO words form one burst, last word tagged.
    function automatic void planChunk(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = model_q.pop_front();
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
        exp_wc = exp_wc + 16'(n);
    endfunction

    // Reference: bursts start while the FIFO is at threshold (or flushing),
    // each taking min(BURST_LEN, words present).
    function automatic void planBursts(input bit use_flush);
        int n;
        while (model_q.size() > 0 && (model_q.size() >= THR || use_flush)) begin
            n = (model_q.size() < BURST_LEN) ? model_q.size() : BURST_LEN;
            planChunk(n);
        end
    endfunction

    task automatic waitDone(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && !busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        repeat (6) @(negedge clk);
    endtask

    task automatic applyStimulus(input int n, input bit use_flush, input int pct);
        for (int i = 0; i < n; i++) writeWord($urandom);
        repeat (2) tick();
        planBursts(use_flush);
        ready_mode = 1;
        ready_pct  = pct;
        flush      = use_flush;
        enable     = 1'b1;
        waitDone("random");
        tick();
        enable      = 1'b0;
        flush       = 1'b0;
        ready_mode  = 0;
        ready_fixed = 1'b1;
        checkOutput("random_word_count", 32'(word_count), 32'(exp_wc));
    endtask

    initial begin
        int rd_before;
        int n;

        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int rd_before;
        int n;

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_m_last", 32'(m_last), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err_underflow), 32'd0);
        checkOutput("rst_m_data", m_data, 32'd0);
        checkOutput("rst_word_count", 32'(word_count), 32'd0);

        // Full bursts of 0x1..0x8 with latency and gapless delivery.
        tick();
        for (int i = 1; i <= 8; i++) writeWord(32'(i));
        repeat (2) tick();
        planBursts(1'b0);
        rd_before = rd_total;
        gapless   = 1'b1;
        enable    = 1'b1;
        @(negedge clk);
        checkOutput("lat_c0_rd", 32'(fifo_rd), 32'd0);
        @(negedge clk);
        checkOutput("lat_c1_rd", 32'(fifo_rd), 32'd1);
        @(negedge clk);
        checkOutput("lat_c2_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat_c3_valid", 32'(m_valid), 32'd1);
        waitDone("full");
        tick();
        enable  = 1'b0;
        gapless = 1'b0;
        checkOutput("full_word_count", 32'(word_count), 32'd8);
        checkOutput("full_reads", 32'(rd_total - rd_before), 32'd8);

        // Flush-driven short burst below threshold.
        writeWord(32'hA);
        writeWord(32'hB);
        writeWord(32'hC);
        repeat (2) tick();
        planBursts(1'b1);
        rd_before = rd_total;
        flush  = 1'b1;
        enable = 1'b1;
        waitDone("flush");
        tick();
        flush  = 1'b0;
        enable = 1'b0;
        checkOutput("flush_reads", 32'(rd_total - rd_before), 32'd3);
        checkOutput("flush_idle", 32'(busy), 32'd0);
        checkOutput("flush_word_count", 32'(word_count), 32'd11);

        // Back-pressure with m_ready pattern 1,0,0.
        for (int i = 0; i < 4; i++) writeWord(32'h100 + 32'(i));
        repeat (2) tick();
        planBursts(1'b0);
        pat_idx    = 0;
        ready_mode = 2;
        enable     = 1'b1;
        waitDone("backpressure");
        tick();
        enable      = 1'b0;
        ready_mode  = 0;
        ready_fixed = 1'b1;
        checkOutput("bp_word_count", 32'(word_count), 32'(exp_wc));

        // Enable low blocks bursts; dropping it mid-burst lets the burst finish.
        for (int i = 0; i < 5; i++) writeWord(32'h200 + 32'(i));
        repeat (2) tick();
        rd_before = rd_total;
        repeat (10) tick();
        checkOutput("enable_low_reads", 32'(rd_total - rd_before), 32'd0);
        planChunk(BURST_LEN);
        enable = 1'b1;
        n = 0;
        while (!fifo_rd && n < 10) begin
            @(negedge clk);
            n++;
        end
        tick();
        enable = 1'b0;
        waitDone("enable_mid");
        repeat (20) tick();
        checkOutput("enable_mid_reads", 32'(rd_total - rd_before), 32'd4);
        checkOutput("enable_mid_idle", 32'(busy), 32'd0);

        // Sticky underflow flag.
        @(negedge clk);
        checkOutput("err_before", 32'(err_underflow), 32'd0);
        tick();
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        @(negedge clk);
        checkOutput("err_set", 32'(err_underflow), 32'd1);
        repeat (5) tick();
        @(negedge clk);
        checkOutput("err_hold", 32'(err_underflow), 32'd1);

        // Reset mid-burst with the consumer stalled: two words are read ahead and lost.
        for (int i = 0; i < 5; i++) writeWord(32'h300 + 32'(i));
        repeat (2) tick();
        ready_mode  = 0;
        ready_fixed = 1'b0;
        enable      = 1'b1;
        n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rstmid_valid_seen", 32'(m_valid), 32'd1);
        repeat (4) @(negedge clk);
        tick();
        rst    = 1'b1;
        enable = 1'b0;
        tick();
        rst = 1'b0;
        void'(model_q.pop_front());
        void'(model_q.pop_front());
        exp_wc = 16'd0;
        @(negedge clk);
        checkOutput("rstmid_fifo_rd", 32'(fifo_rd), 32'd0);
        checkOutput("rstmid_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rstmid_m_last", 32'(m_last), 32'd0);
        checkOutput("rstmid_busy", 32'(busy), 32'd0);
        checkOutput("rstmid_err", 32'(err_underflow), 32'd0);
        checkOutput("rstmid_m_data", m_data, 32'd0);
        checkOutput("rstmid_word_count", 32'(word_count), 32'd0);
        tick();
        ready_fixed = 1'b1;
        planBursts(1'b0);
        enable = 1'b1;
        waitDone("after_reset");
        tick();
        enable = 1'b0;
        checkOutput("after_reset_word_count", 32'(word_count), 32'd4);

        // Randomized phases, then a final flush to drain any leftovers.
        for (int p = 0; p < 10; p++) begin
            applyStimulus($urandom_range(1, 9), 1'($urandom_range(0, 1)),
                          $urandom_range(30, 100));
        end
        applyStimulus(0, 1'b1, 100);
        checkOutput("fifo_drained", 32'(phys_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side controller for the 32-bit synchronous FIFO (`fifo_mem`). It watches the FIFO status flags and issues `rd` pulses in bursts of up to BURST_LEN words. Returned words are pushed onto a valid/ready output stream, with `m_last` framing each burst. It sits between `fifo_mem` and the downstream consumer, and it is the counterpart of the upstream writer that drives `wr`/`data_in`.

## Interface
- `DATA_W`, 32: word width; must match the FIFO width.
- `BURST_LEN`, 4: maximum words per burst, legal range 2..255.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: allows new bursts to start; a burst in progress always completes.
- `flush` input 1: level signal; while high, a burst may start below threshold.
- `fifo_rd` output 1: one-cycle read strobe to the FIFO `rd` input.
- `fifo_data` input DATA_W: FIFO read data, valid the cycle after `fifo_rd`.
- `fifo_empty` input 1: FIFO empty flag; reflects the post-read state in the cycle after a read.
- `fifo_threshold` input 1: FIFO at or above its threshold.
- `fifo_underflow` input 1: FIFO underflow flag.
- `m_data` output DATA_W: output word.
- `m_valid` output 1: output word valid.
- `m_ready` input 1: consumer accepts the output word.
- `m_last` output 1: marks the final word of a burst.
- `busy` output 1: high whenever the state is not IDLE.
- `err_underflow` output 1: sticky; set when `fifo_underflow` is seen; cleared only by `rst`.
- `word_count` output 16: number of words accepted on the output (`m_valid && m_ready`); wraps modulo 2^16.

## Operation
- The FSM has three states: IDLE, READ and DRAIN.
- **IDLE → READ** when `enable && !fifo_empty && (fifo_threshold || flush)`.
  - The issued count `rd_cnt` is cleared on entry.
- **READ, issuing reads.** Assert `fifo_rd` when all of the following hold:
  - `!fifo_empty`
  - `rd_cnt < BURST_LEN`
  - no last-tagged word has been captured
  - `occ + inflight - pop < 2`, where:
    - `occ` is the output buffer occupancy;
    - `inflight` is 1 if `fifo_rd` was high last cycle;
    - `pop` is `m_valid && m_ready` this cycle.
  - Each read increments `rd_cnt`.
- **READ, capturing data.** In the cycle after a read, `fifo_data` is written to the output buffer with a last tag.
  - The tag is set if the word index is BURST_LEN-1, or if `fifo_empty` is high in the capture cycle.
- **READ → DRAIN** in the cycle a last-tagged word is captured.
- **DRAIN → IDLE** when the buffer is empty after a pop in that cycle. No further reads are issued in DRAIN.
- **Output buffer** is a 2-entry FIFO.
  - `m_data`, `m_valid` and `m_last` come from its head.
  - The head holds stable while `m_valid && !m_ready`.
- **Underflow.** If `fifo_underflow` is high on any cycle, `err_underflow` is set. The FSM is unaffected.
- **Flush.** Lowering `flush` mid-burst does not shorten the burst.

## Timing
- **Reset values:**
  - `fifo_rd`, `m_valid`, `m_last`, `busy` and `err_underflow` are 0.
  - `m_data` and `word_count` are 0.
  - The state is IDLE, the buffer is empty, and in-flight data is discarded.
- **Reset asserted mid-burst** takes effect at the next edge, with no partial outputs afterwards.
- **Latency:**
  - Trigger sampled at cycle 0.
  - First `fifo_rd` at cycle 1.
  - Data captured at cycle 2.
  - `m_valid` at cycle 3.
- **Throughput:** with `m_ready` held high, one word per cycle. Reads are back-to-back while the FIFO stays non-empty.
- **Back-pressure:** `m_ready` low stalls reads within 1 cycle; the buffer never overflows.
- **Simultaneous push and pop** on the buffer are both honoured in the same cycle.
- **Burst gap:** after DRAIN → IDLE, the next burst's first `fifo_rd` comes no earlier than 2 cycles later.

## Structure
- Package `fifo_rd_pkg` holds:
  - the state enum (IDLE, READ, DRAIN);
  - the default BURST_LEN;
  - the buffer depth constant (2).
- Sub-module `fifo_rd_skid`: the 2-entry output buffer, carrying `{last, data}` with push, pop and occupancy.
- The top level contains the FSM, read counter, in-flight flag, error flag and word counter.

## Test plan
- **Full burst:** write 8 words 0x1..0x8, threshold high, `m_ready`=1.
  - Two bursts: 1..4 with `m_last` on 0x4, then 5..8 with `m_last` on 0x8.
  - `word_count` = 8; no idle cycles within a burst.
- **Flush short burst:** 3 words 0xA,0xB,0xC, threshold low, `flush`=1.
  - One burst of 3 words with `m_last` on 0xC; FSM ends in IDLE; `fifo_rd` is asserted exactly 3 times.
- **Back-pressure:** 4 words, `m_ready` toggled 1,0,0,1,...
  - No duplicated or lost words.
  - `m_data` stable while stalled.
  - At most 2 words are read ahead of acceptance.
- **Enable low:** threshold high with `enable`=0 → no `fifo_rd`.
  - Deassert `enable` mid-burst → the current burst completes, and no new burst starts.
- **Underflow and reset:** pulse `fifo_underflow` → `err_underflow`=1 and holds.
  - Assert `rst` mid-burst → all outputs 0 next cycle and `word_count`=0.
  - After release, the remaining FIFO words are delivered normally.
